// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel synchronizer, debouncer, edge, long-press and auto-repeat conditioner
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   async_in    [WIDTH] raw asynchronous inputs, active-high
//   level       [WIDTH] debounced level per channel
//   press       [WIDTH] 1-cycle pulse on debounced rise or auto-repeat tick
//   released    [WIDTH] 1-cycle pulse on debounced fall
//   long_press  [WIDTH] 1-cycle pulse once a press has lasted HOLD_SAMPLES ticks
//   repeating   [WIDTH] high while the channel is held with auto-repeat enabled
module input_conditioner #(
  parameter int               WIDTH          = 7,
  parameter int               SYNC_STAGES    = 2,
  parameter int               SAMPLE_PERIOD  = 25000,
  parameter int               SAT_MAX        = 150,
  parameter int               HOLD_SAMPLES   = 40,
  parameter int               REPEAT_SAMPLES = 10,
  parameter logic [WIDTH-1:0] REPEAT_MASK    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] released,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] repeating
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int SW = $clog2(SAT_MAX + 1);
  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam int RW = $clog2(REPEAT_SAMPLES + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [SW-1:0] SAT_TOP   = SW'(SAT_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SAMPLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  // Shared sample-tick generator; first tick lands SAMPLE_PERIOD cycles after reset.
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Synchronizer chain, all channels side by side.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SW-1:0] sat;
    logic          prev;
    logic          rise, fall;
    state_t        state, state_d;
    logic [HW-1:0] hc, hc_d;
    logic [RW-1:0] rc, rc_d;
    logic          hold_hit, rep_hit;
    logic          press_q, release_q, long_q;

    // A single low sample clears the count, so only an unbroken run of highs saturates.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sat <= '0;
      end else if (tick) begin
        if (!s[i])              sat <= '0;
        else if (sat != SAT_TOP) sat <= sat + 1'b1;
      end
    end

    assign level[i] = (sat == SAT_TOP);
    assign rise     = level[i] & ~prev;
    assign fall     = ~level[i] & prev;

    // A fall overrides any threshold in the same cycle.
    always_comb begin
      state_d  = state;
      hc_d     = hc;
      rc_d     = rc;
      hold_hit = 1'b0;
      rep_hit  = 1'b0;
      if (fall) begin
        state_d = IDLE;
        hc_d    = '0;
        rc_d    = '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state_d = PRESSED;
              hc_d    = '0;
            end
          end
          PRESSED: begin
            if (tick) begin
              if (hc == HOLD_LAST) begin
                hold_hit = 1'b1;
                state_d  = HELD;
                rc_d     = '0;
              end else begin
                hc_d = hc + 1'b1;
              end
            end
          end
          HELD: begin
            if (REPEAT_MASK[i] && tick) begin
              if (rc == REP_LAST) begin
                rep_hit = 1'b1;
                rc_d    = '0;
              end else begin
                rc_d = rc + 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        hc        <= '0;
        rc        <= '0;
        prev      <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_d;
        hc        <= hc_d;
        rc        <= rc_d;
        prev      <= level[i];
        press_q   <= rise | rep_hit;
        release_q <= fall;
        long_q    <= hold_hit;
      end
    end

    assign press[i]      = press_q;
    assign released[i]   = release_q;
    assign long_press[i] = long_q;
    assign repeating[i]  = (state == HELD) & REPEAT_MASK[i];
  end

endmodule
